// File: rtl/mem_pkg.sv
// Shared encodings and payload types for the MEM stage: access kinds, funct3 sizes,
// FSM states, bus request payload and MEM/WB register contents.
package mem_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] MC_NONE  = 2'b00;
  localparam logic [1:0] MC_LOAD  = 2'b01;
  localparam logic [1:0] MC_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
  } mem_bus_t;

  typedef struct packed {
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] readdata;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc_next;
    logic            fault;
  } wb_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store replication and enables, load extract/extend,
// and detection of illegal or misaligned accesses.
module load_store_align
  import mem_pkg::*;
(
  input  logic [1:0]      mem_con_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic            bad_c_o,
  output logic [3:0]      be_c_o,
  output logic [XLEN-1:0] wdata_c_o,
  output logic [XLEN-1:0] load_data_c_o
);

  logic        is_load;
  logic        is_store;
  logic        legal;
  logic        misalign;
  logic [15:0] shifted;

  always_comb begin
    is_load       = (mem_con_i == MC_LOAD);
    is_store      = (mem_con_i == MC_STORE);
    misalign      = 1'b0;
    be_c_o        = 4'b1111;
    wdata_c_o     = store_data_i;
    load_data_c_o = rdata_i;
    shifted       = 16'(rdata_i >> {addr_lo_i, 3'b000});

    // funct3[1:0] encodes the access size for both loads and stores
    case (funct3_i[1:0])
      2'b00: begin
        be_c_o    = 4'b0001 << addr_lo_i;
        wdata_c_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_c_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_c_o = {2{store_data_i[15:0]}};
        misalign  = addr_lo_i[0];
      end
      default: misalign = (addr_lo_i != 2'b00);
    endcase

    case (funct3_i)
      F3_B:    load_data_c_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_c_o = {24'd0, shifted[7:0]};
      F3_H:    load_data_c_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_c_o = {16'd0, shifted[15:0]};
      default: load_data_c_o = rdata_i;
    endcase

    if (is_load)
      legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W) ||
              (funct3_i == F3_BU) || (funct3_i == F3_HU);
    else
      legal = (funct3_i == F3_B) || (funct3_i == F3_H) || (funct3_i == F3_W);

    bad_c_o = (is_load || is_store) && (!legal || misalign);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns EX/MEM load/store requests into req/ack bus transactions,
// stalls the pipeline while waiting, and registers the MEM/WB values.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWrite_EX,
  input  logic [1:0]      ResultSrc_EX,
  input  logic [1:0]      Mem_Con_EX,
  input  logic [2:0]      funct3_EX,
  input  logic [XLEN-1:0] ALUresult_EX,
  input  logic [XLEN-1:0] data2_EX,
  input  logic [4:0]      rd_EX,
  input  logic [XLEN-1:0] PC_next_EX,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            RegWrite_MEM,
  output logic [1:0]      ResultSrc_MEM,
  output logic [XLEN-1:0] ALUresult_MEM,
  output logic [XLEN-1:0] ReadData_MEM,
  output logic [4:0]      rd_MEM,
  output logic [XLEN-1:0] PC_next_MEM,
  output logic            fault_MEM
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;
  mem_bus_t         bus_q, bus_d;
  wb_t              wb_q, wb_d;
  wb_t              wb_cap;
  logic             stall_c;
  logic             access;
  logic             is_load;
  logic             timeout_hit;
  logic             bad_c;
  logic [3:0]       be_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  load_data_c;

  load_store_align u_align (
    .mem_con_i     (Mem_Con_EX),
    .funct3_i      (funct3_EX),
    .addr_lo_i     (ALUresult_EX[1:0]),
    .store_data_i  (data2_EX),
    .rdata_i       (mem_rdata),
    .bad_c_o       (bad_c),
    .be_c_o        (be_c),
    .wdata_c_o     (wdata_c),
    .load_data_c_o (load_data_c)
  );

  assign is_load     = (Mem_Con_EX == MC_LOAD);
  assign access      = is_load || (Mem_Con_EX == MC_STORE);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      bus_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      bus_q   <= bus_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    bus_d   = bus_q;
    wb_d    = wb_q;
    stall_c = 1'b0;
    wb_cap  = '{regwrite: RegWrite_EX, resultsrc: ResultSrc_EX, aluresult: ALUresult_EX,
                readdata: '0, rd: rd_EX, pc_next: PC_next_EX, fault: 1'b0};

    case (state_q)
      S_IDLE: begin
        if (access && !bad_c) begin
          stall_c     = 1'b1;
          state_d     = S_WAIT;
          req_d       = 1'b1;
          cnt_d       = '0;
          bus_d       = '{we: !is_load, addr: {ALUresult_EX[XLEN-1:2], 2'b00},
                          wdata: wdata_c, be: be_c};
          wb_d.regwrite = 1'b0;
          wb_d.fault    = 1'b0;
        end else begin
          // Non-memory ops and rejected accesses flow straight through
          wb_d          = wb_cap;
          wb_d.regwrite = RegWrite_EX && !bad_c;
          wb_d.fault    = bad_c;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          wb_d = wb_cap;
          if (is_load) wb_d.readdata = load_data_c;
          req_d   = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (timeout_hit) begin
          wb_d          = wb_cap;
          wb_d.regwrite = 1'b0;
          wb_d.fault    = 1'b1;
          req_d         = 1'b0;
          state_d       = S_IDLE;
          cnt_d         = '0;
        end else begin
          stall_c       = 1'b1;
          cnt_d         = cnt_q + CNT_W'(1);
          wb_d.regwrite = 1'b0;
          wb_d.fault    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall must fall with reset even though the EX/MEM inputs may still hold a request
  assign stall         = stall_c && rst;
  assign mem_req       = req_q;
  assign mem_we        = bus_q.we;
  assign mem_addr      = bus_q.addr;
  assign mem_wdata     = bus_q.wdata;
  assign mem_be        = bus_q.be;
  assign RegWrite_MEM  = wb_q.regwrite;
  assign ResultSrc_MEM = wb_q.resultsrc;
  assign ALUresult_MEM = wb_q.aluresult;
  assign ReadData_MEM  = wb_q.readdata;
  assign rd_MEM        = wb_q.rd;
  assign PC_next_MEM   = wb_q.pc_next;
  assign fault_MEM     = wb_q.fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions checked against a byte-lane reference model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RegWrite_EX;
  logic [1:0]  ResultSrc_EX;
  logic [1:0]  Mem_Con_EX;
  logic [2:0]  funct3_EX;
  logic [31:0] ALUresult_EX;
  logic [31:0] data2_EX;
  logic [4:0]  rd_EX;
  logic [31:0] PC_next_EX;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        RegWrite_MEM;
  logic [1:0]  ResultSrc_MEM;
  logic [31:0] ALUresult_MEM;
  logic [31:0] ReadData_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] PC_next_MEM;
  logic        fault_MEM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_EX(RegWrite_EX), .ResultSrc_EX(ResultSrc_EX), .Mem_Con_EX(Mem_Con_EX),
    .funct3_EX(funct3_EX), .ALUresult_EX(ALUresult_EX), .data2_EX(data2_EX),
    .rd_EX(rd_EX), .PC_next_EX(PC_next_EX),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .RegWrite_MEM(RegWrite_MEM), .ResultSrc_MEM(ResultSrc_MEM), .ALUresult_MEM(ALUresult_MEM),
    .ReadData_MEM(ReadData_MEM), .rd_MEM(rd_MEM), .PC_next_MEM(PC_next_MEM), .fault_MEM(fault_MEM)
  );

  // Reference model: size in bytes from funct3, alignment by modulo arithmetic
  function automatic logic exp_bad(logic [1:0] mc, logic [2:0] f3, logic [31:0] a);
    int nb;
    if (mc != 2'b01 && mc != 2'b10) return 1'b0;
    if (mc == 2'b01 && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
    if (mc == 2'b10 && f3 > 3'd2) return 1'b1;
    nb = 1 << f3[1:0];
    return (a % nb) != 0;
  endfunction

  function automatic logic [3:0] exp_be(logic [2:0] f3, logic [31:0] a);
    int nb;
    nb = 1 << f3[1:0];
    return 4'(((32'd1 << nb) - 32'd1) << a[1:0]);
  endfunction

  function automatic logic [31:0] exp_wdata(logic [2:0] f3, logic [31:0] d);
    if (f3[1:0] == 2'b00) return {24'd0, d[7:0]} * 32'h0101_0101;
    if (f3[1:0] == 2'b01) return {16'd0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdata);
    int nb;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    nb  = 1 << f3[1:0];
    off = int'(a[1:0]);
    if (nb >= 4) return rdata;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = (rdata >> (8 * off)) & mask;
    if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Presents one EX/MEM instruction (called at posedge+1), returns at posedge+1 after completion
  task automatic run_txn(input logic [1:0] mc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] d2, input logic [4:0] rd, input logic rw,
                         input logic [1:0] rs, input logic [31:0] pc, input int ack_delay,
                         input logic [31:0] rdata, output int stall_cycles);
    logic bad, acc, tmo, done;
    logic [31:0] rd_exp;
    int w;
    Mem_Con_EX = mc; funct3_EX = f3; ALUresult_EX = addr; data2_EX = d2;
    rd_EX = rd; RegWrite_EX = rw; ResultSrc_EX = rs; PC_next_EX = pc;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    bad = exp_bad(mc, f3, addr);
    acc = (mc == 2'b01) || (mc == 2'b10);
    tmo = 1'b0;
    stall_cycles = 0;
    @(negedge clk);
    checks++;
    if (stall !== (acc && !bad)) begin
      errors++; $display("FAIL idle_stall: got %b want %b", stall, acc && !bad);
    end
    if (stall === 1'b1) stall_cycles++;
    if (acc && !bad) begin
      w = 0; done = 1'b0;
      while (!done) begin
        @(posedge clk); #1;
        if (w == ack_delay) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== (mc == 2'b10) || mem_addr !== {addr[31:2], 2'b00} ||
            mem_be !== exp_be(f3, addr)) begin
          errors++;
          $display("FAIL bus_req: got req=%b we=%b addr=%h be=%b want req=1 we=%b addr=%h be=%b",
                   mem_req, mem_we, mem_addr, mem_be, mc == 2'b10, {addr[31:2], 2'b00}, exp_be(f3, addr));
        end
        if (mc == 2'b10) begin
          checks++;
          if (mem_wdata !== exp_wdata(f3, d2)) begin
            errors++; $display("FAIL bus_wdata: got %h want %h", mem_wdata, exp_wdata(f3, d2));
          end
        end
        checks++;
        if (RegWrite_MEM !== 1'b0 || fault_MEM !== 1'b0) begin
          errors++; $display("FAIL bubble: got rw=%b fault=%b want 0 0", RegWrite_MEM, fault_MEM);
        end
        if (w == ack_delay || w == int'(TO) - 1) begin
          done = 1'b1;
          tmo  = (w != ack_delay);
        end
        checks++;
        if (stall !== !done) begin
          errors++; $display("FAIL wait_stall: got %b want %b (wait %0d)", stall, !done, w);
        end
        if (stall === 1'b1) stall_cycles++;
        w++;
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    rd_exp = (acc && !bad && !tmo && mc == 2'b01) ? exp_load(f3, addr, rdata) : 32'h0;
    checks++;
    if (RegWrite_MEM !== (rw && !bad && !tmo) || fault_MEM !== (bad || tmo) ||
        ReadData_MEM !== rd_exp || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL wb_ctrl: got rw=%b fault=%b data=%h req=%b want rw=%b fault=%b data=%h req=0",
               RegWrite_MEM, fault_MEM, ReadData_MEM, mem_req, rw && !bad && !tmo, bad || tmo, rd_exp);
    end
    checks++;
    if (ALUresult_MEM !== addr || rd_MEM !== rd || PC_next_MEM !== pc || ResultSrc_MEM !== rs) begin
      errors++;
      $display("FAIL wb_pass: got alu=%h rd=%0d pc=%h rs=%b want alu=%h rd=%0d pc=%h rs=%b",
               ALUresult_MEM, rd_MEM, PC_next_MEM, ResultSrc_MEM, addr, rd, pc, rs);
    end
  endtask

  task automatic test_reset();
    Mem_Con_EX = 2'b01; funct3_EX = 3'b010; ALUresult_EX = 32'h100; data2_EX = 32'h0;
    rd_EX = 5'd1; RegWrite_EX = 1'b1; ResultSrc_EX = 2'b01; PC_next_EX = 32'h4;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    checks++;
    if (stall !== 1'b0 || mem_req !== 1'b0 || RegWrite_MEM !== 1'b0 || fault_MEM !== 1'b0 ||
        ALUresult_MEM !== 32'h0 || mem_addr !== 32'h0 || rd_MEM !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: got stall=%b req=%b rw=%b fault=%b alu=%h addr=%h rd=%0d want all 0",
               stall, mem_req, RegWrite_MEM, fault_MEM, ALUresult_MEM, mem_addr, rd_MEM);
    end
    Mem_Con_EX = 2'b00;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_op();
    int sc;
    run_txn(2'b00, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b1, 2'b00, 32'h44, 0, 32'h0, sc);
    checks++;
    if (sc != 0) begin errors++; $display("FAIL alu_stall: got %0d want 0", sc); end
  endtask

  task automatic test_lb_lbu();
    int sc;
    run_txn(2'b01, 3'b000, 32'h1003, 32'h0, 5'd7, 1'b1, 2'b01, 32'h50, 3, 32'h80FF_FFFF, sc);
    checks++;
    if (sc != 4 || ReadData_MEM !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb: got stall=%0d data=%h want 4 ffffff80", sc, ReadData_MEM);
    end
    run_txn(2'b01, 3'b100, 32'h1003, 32'h0, 5'd7, 1'b1, 2'b01, 32'h54, 3, 32'h80FF_FFFF, sc);
    checks++;
    if (sc != 4 || ReadData_MEM !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu: got stall=%0d data=%h want 4 00000080", sc, ReadData_MEM);
    end
  endtask

  task automatic test_sh();
    int sc;
    run_txn(2'b10, 3'b001, 32'h2002, 32'hDEAD_BEEF, 5'd0, 1'b0, 2'b00, 32'h60, 0, 32'h0, sc);
    checks++;
    if (sc != 1) begin errors++; $display("FAIL sh_stall: got %0d want 1", sc); end
  endtask

  task automatic test_misaligned();
    int sc;
    run_txn(2'b01, 3'b010, 32'h3001, 32'h0, 5'd9, 1'b1, 2'b01, 32'h70, 0, 32'h0, sc);
    checks++;
    if (sc != 0 || fault_MEM !== 1'b1) begin
      errors++; $display("FAIL misaligned: got stall=%0d fault=%b want 0 1", sc, fault_MEM);
    end
    run_txn(2'b10, 3'b100, 32'h3000, 32'h0, 5'd9, 1'b0, 2'b00, 32'h74, 0, 32'h0, sc);
  endtask

  task automatic test_timeout();
    int sc;
    run_txn(2'b01, 3'b010, 32'h4000, 32'h0, 5'd3, 1'b1, 2'b01, 32'h80, 100, 32'h0, sc);
    checks++;
    if (sc != 4 || fault_MEM !== 1'b1) begin
      errors++; $display("FAIL timeout: got stall=%0d fault=%b want 4 1", sc, fault_MEM);
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    Mem_Con_EX = 2'b01; funct3_EX = 3'b010; ALUresult_EX = 32'h5000; RegWrite_EX = 1'b1;
    rd_EX = 5'd4; mem_ack = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req: got %b want 1", mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0 || mem_addr !== 32'h0 || RegWrite_MEM !== 1'b0 ||
        ALUresult_MEM !== 32'h0 || fault_MEM !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got req=%b stall=%b addr=%h rw=%b alu=%h fault=%b want all 0",
               mem_req, stall, mem_addr, RegWrite_MEM, ALUresult_MEM, fault_MEM);
    end
    Mem_Con_EX = 2'b00; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL stray_ack: got req=%b stall=%b want 0 0", mem_req, stall);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    run_txn(2'b01, 3'b001, 32'h5002, 32'h0, 5'd4, 1'b1, 2'b01, 32'h90, 1, 32'h1234_8765, sc);
    checks++;
    if (sc != 2 || ReadData_MEM !== 32'h0000_1234) begin
      errors++; $display("FAIL post_reset_lh: got stall=%0d data=%h want 2 00001234", sc, ReadData_MEM);
    end
  endtask

  task automatic test_random();
    int sc;
    logic [1:0]  mc;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [2:0]  legal [5];
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
    for (int i = 0; i < 60; i++) begin
      mc = 2'($urandom_range(0, 3));
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal[$urandom_range(0, 4)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
      run_txn(mc, f3, a, $urandom, 5'($urandom), 1'($urandom), 2'($urandom), $urandom,
              $urandom_range(0, 5), $urandom, sc);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
